// File: rtl/decoder_rr_sched.sv
// ----------------------------------------------------------------------------
// decoder_rr_sched
//
// Round-robin scheduler that shares one 4-to-16 decoder among 16 requesters.
// It picks one active request, drives the decoder select code {x,y,z,w} and
// enable so that exactly one decoder line acts as that requester's grant,
// holds the grant until the holder finishes (done), drops its request, or the
// hold limit expires, then inserts one dead cycle before re-arbitrating.
//
// Requester i pairs with decoder output d[i], which is select code 15-i.
// For a 4-bit code c, 15-c is simply ~c, which is how the holder's request
// bit is looked up below.
//
// Parameters:
//   HOLD_MAX  maximum number of cycles a grant may be held (1..255)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   req[15:0] level-sensitive request lines
//   done      current holder releases its grant (sampled only in GRANT)
//   x,y,z,w   registered decoder select code, x is the MSB
//   enable    registered decoder enable, high only in GRANT
//   busy      high in GRANT and GAP
//   timeout   one-cycle pulse in GAP when a grant was forcibly revoked
// ----------------------------------------------------------------------------
module decoder_rr_sched #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        w,
    output logic        enable,
    output logic        busy,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    logic [1:0] r_state;
    logic [3:0] r_code;
    logic [3:0] r_last;
    logic [7:0] r_cnt;
    logic       r_enable;
    logic       r_busy;
    logic       r_timeout;

    logic       w_found;
    logic [3:0] w_win;
    logic       w_holder_req;
    logic       w_limit_hit;
    logic       w_release;
    logic       w_forced;

    // Round-robin search: codes last+1, last+2, ... wrapping mod 16. The last
    // candidate examined is 'last' itself, so a holder that re-requests right
    // away gets the lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment would infer a latch.
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] cand;
            cand = r_last + 4'(k);
            if (!w_found && req[~cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    assign w_holder_req = req[~r_code];
    assign w_limit_hit  = (r_cnt == HOLD_LIMIT);
    assign w_release    = done || !w_holder_req || w_limit_hit;
    // A release is only a timeout when the limit is the sole cause.
    assign w_forced     = w_limit_hit && !done && w_holder_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_code    <= 4'd0;
            r_last    <= 4'd15;
            r_cnt     <= 8'd0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_GRANT;
                        r_code   <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= 8'd1;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state   <= ST_GAP;
                        r_enable  <= 1'b0;
                        r_timeout <= w_forced;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign x       = r_code[3];
    assign y       = r_code[2];
    assign z       = r_code[1];
    assign w       = r_code[0];
    assign enable  = r_enable;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
